// File: rtl/bcd_scan_counter_pkg.sv
// rtl/bcd_scan_counter_pkg.sv - shared constants and helpers for the BCD scan counter
package bcd_scan_counter_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_THOUS = 2'd3;

    function automatic logic [3:0] bcd_nibble(input logic [15:0] bcd, input logic [1:0] idx);
        return bcd[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade of the BCD counter with carry/borrow chaining
module bcd_digit
    import bcd_scan_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       step_in,
    input  logic       up_dn,
    output logic [3:0] value,
    output logic [3:0] value_nxt,
    output logic       step_out
);

    logic at_limit;

    // value_nxt is exported so the scan path can show the post-step value without skew
    always_comb begin
        at_limit  = up_dn ? (value == BCD_MAX) : (value == 4'd0);
        step_out  = step_in & at_limit;
        value_nxt = value;
        if (clr) begin
            value_nxt = 4'd0;
        end else if (step_in) begin
            if (up_dn) begin
                value_nxt = at_limit ? 4'd0 : value + 4'd1;
            end else begin
                value_nxt = at_limit ? BCD_MAX : value - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-digit up/down BCD counter with multiplexed digit scan
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int COUNT_DIV = 50_000_000,
    parameter int SCAN_DIV  = 50_000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up_dn,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic [3:0]  digit_val,
    output logic [1:0]  digit_sel,
    output logic        carry_out
);

    localparam int PW = (COUNT_DIV > 2) ? $clog2(COUNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [PW-1:0]         pre_cnt;
    logic [SW-1:0]         scan_cnt;
    logic                  tick;
    logic                  step;
    logic                  scan_wrap;
    logic [NUM_DIGITS:0]   chain;
    logic [15:0]           count_nxt;
    logic [1:0]            sel_nxt;

    assign tick      = (pre_cnt == PRE_LAST);
    assign step      = tick & en & ~clr;
    assign chain[0]  = step;
    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign sel_nxt   = scan_wrap ? digit_sel + 2'd1 : digit_sel;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .step_in   (chain[g]),
            .up_dn     (up_dn),
            .value     (count_bcd[4*g +: 4]),
            .value_nxt (count_nxt[4*g +: 4]),
            .step_out  (chain[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            carry_out <= 1'b0;
        end else begin
            pre_cnt   <= (clr || tick) ? '0 : pre_cnt + 1'b1;
            carry_out <= chain[NUM_DIGITS];
        end
    end

    // Scan runs free of en/clr; digit_val is built from next-state values so it never lags digit_sel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_sel <= DIG_UNITS;
            digit_val <= 4'd0;
        end else begin
            scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
            digit_sel <= sel_nxt;
            digit_val <= bcd_nibble(count_nxt, sel_nxt);
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] count_bcd;
    logic [3:0]  digit_val;
    logic [1:0]  digit_sel;
    logic        carry_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bcd_scan_counter #(.COUNT_DIV(4), .SCAN_DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up_dn     (up_dn),
        .clr       (clr),
        .count_bcd (count_bcd),
        .digit_val (digit_val),
        .digit_sel (digit_sel),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        if (rst_n) cyc++;
        @(negedge clk);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [1:0] exp_sel();
        return 2'((cyc / 2) % 4);
    endfunction

    initial begin
        logic [15:0] exp;
        logic [1:0]  es;
        bit          found;

        repeat (2) clk_cycle();
        chk("rst_count", count_bcd, 16'h0000);
        chk("rst_sel", {14'd0, digit_sel}, 16'd0);
        chk("rst_val", {12'd0, digit_val}, 16'd0);
        chk("rst_carry", {15'd0, carry_out}, 16'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        up_dn = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            clk_cycle();
            exp = to_bcd(k / 4);
            es  = exp_sel();
            chk("up_count", count_bcd, exp);
            chk("up_carry", {15'd0, carry_out}, 16'd0);
            chk("up_sel", {14'd0, digit_sel}, {14'd0, es});
            chk("up_val", {12'd0, digit_val}, {12'd0, nib(exp, int'(es))});
        end
        chk("up_40", count_bcd, 16'h0010);

        clr = 1'b1;
        clk_cycle();
        clr = 1'b0;
        chk("clr_count", count_bcd, 16'h0000);
        chk("clr_carry", {15'd0, carry_out}, 16'd0);
        up_dn = 1'b0;
        repeat (3) clk_cycle();
        chk("dn_pre", count_bcd, 16'h0000);
        clk_cycle();
        chk("dn_wrap", count_bcd, 16'h9999);
        chk("dn_wrap_carry", {15'd0, carry_out}, 16'd1);
        clk_cycle();
        chk("dn_carry_end", {15'd0, carry_out}, 16'd0);
        repeat (2) clk_cycle();
        chk("dn_hold", count_bcd, 16'h9999);
        clk_cycle();
        chk("dn_9998", count_bcd, 16'h9998);
        up_dn = 1'b1;
        repeat (4) clk_cycle();
        chk("up_9999", count_bcd, 16'h9999);
        chk("up_9999_carry", {15'd0, carry_out}, 16'd0);
        repeat (4) clk_cycle();
        chk("up_wrap", count_bcd, 16'h0000);
        chk("up_wrap_carry", {15'd0, carry_out}, 16'd1);
        clk_cycle();
        chk("up_carry_end", {15'd0, carry_out}, 16'd0);
        chk("up_wrap_hold", count_bcd, 16'h0000);

        repeat (1234 * 4) clk_cycle();
        chk("reach_1234", count_bcd, 16'h1234);
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clk_cycle();
            es = exp_sel();
            chk("scan_sel", {14'd0, digit_sel}, {14'd0, es});
            chk("scan_val", {12'd0, digit_val}, {12'd0, 4'(4 - int'(es))});
            chk("en0_hold", count_bcd, 16'h1234);
        end

        en  = 1'b1;
        clr = 1'b1;
        clk_cycle();
        clr = 1'b0;
        repeat (36) clk_cycle();
        chk("reach_9", count_bcd, 16'h0009);
        repeat (3) clk_cycle();
        chk("pre_tick_9", count_bcd, 16'h0009);
        clr = 1'b1;
        clk_cycle();
        clr = 1'b0;
        chk("clr_tick_count", count_bcd, 16'h0000);
        chk("clr_tick_carry", {15'd0, carry_out}, 16'd0);
        repeat (3) clk_cycle();
        chk("clr_tick_wait", count_bcd, 16'h0000);
        clk_cycle();
        chk("clr_tick_next", count_bcd, 16'h0001);

        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            if (digit_sel == 2'd2) found = 1'b1;
            else clk_cycle();
        end
        chk("find_sel2", {15'd0, found}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_count", count_bcd, 16'h0000);
        chk("arst_sel", {14'd0, digit_sel}, 16'd0);
        chk("arst_val", {12'd0, digit_val}, 16'd0);
        chk("arst_carry", {15'd0, carry_out}, 16'd0);
        clk_cycle();
        rst_n = 1'b1;
        cyc   = 0;
        clk_cycle();
        chk("rel_sel_1cyc", {14'd0, digit_sel}, 16'd0);
        clk_cycle();
        chk("rel_sel_2cyc", {14'd0, digit_sel}, 16'd1);
        chk("rel_count", count_bcd, 16'h0000);
        repeat (2) clk_cycle();
        chk("rel_first_tick", count_bcd, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
